// File: rtl/bpu_update_sched_pkg.sv
// Shared definitions for the branch predictor update scheduler.
// Holds the retire lane count, the per-entry flag layout and a helper that
// gives the packed width of one queue entry:
//     {flags(cond,taken,miss,btb_wr,br_type), index, target, addr}
// with addr in the LSBs.
package bpu_update_sched_pkg;

    localparam int unsigned LANES       = 2;
    localparam int unsigned ENTRY_FLAGS = 5;

    typedef struct packed {
        logic cond;     // predictor update needed
        logic taken;    // resolved direction
        logic miss;     // direction mispredict
        logic btb_wr;   // BTB write requested
        logic br_type;  // 1 = unconditional / forced taken
    } entry_flags_t;

    // Packed width of one queue entry for a given index and address width.
    function automatic int unsigned entry_width(input int unsigned iw, input int unsigned xlen);
        return ENTRY_FLAGS + iw + 2 * xlen;
    endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// Dual-write, single-read circular buffer for BPU update entries.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   wr0_en / wr0_data   : write at the tail pointer
//   wr1_en / wr1_data   : write at tail+1 (only used together with wr0_en)
//   pop                 : retire the head entry (ignored when empty)
//   head_data           : entry at the read pointer (valid when count != 0)
//   count               : number of occupied entries
// Storage is not reset; only pointers and the occupancy count are.
module bpu_update_fifo
    import bpu_update_sched_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr0_en,
    input  logic [W-1:0]               wr0_data,
    input  logic                       wr1_en,
    input  logic [W-1:0]               wr1_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] wptr1_s;
    logic [CW-1:0] push_s;
    logic          pop_s;

    // Second write slot and push/pop amounts; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wptr1_s = wptr_r + PW'(1);
        push_s  = CW'(wr0_en) + CW'(wr1_en);
        pop_s   = pop & (count_r != CW'(0));
    end

    // Entry storage, written in age order at tail and tail+1.
    always_ff @(posedge clock) begin
        if (wr0_en) begin
            mem_r[wptr_r] <= wr0_data;
        end
        if (wr1_en) begin
            mem_r[wptr1_s] <= wr1_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop are allowed.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            wptr_r  <= wptr_r + push_s[PW-1:0];
            rptr_r  <= rptr_r + PW'(pop_s);
            count_r <= count_r + push_s - CW'(pop_s);
        end
    end

    assign head_data = mem_r[rptr_r];
    assign count     = count_r;

endmodule

// File: rtl/bpu_update_sched.sv
// Branch predictor update scheduler.
// Collects up to two retired branch-class instructions per cycle, queues the
// ones that need a predictor or BTB update, and hands exactly one update per
// cycle to the BPU from the queue head (no backpressure from the BPU).
// Ports:
//   clock, reset                     : single clock, synchronous active-high reset
//   retValid/retCond/retTaken/retMiss/retBtbWr/retType [1:0] : per-lane retire info
//   retIndex [2*IW], retTarget/retAddr [2*XLEN]              : per-lane payload, lane0 in LSBs
//   retReady                         : at least two free entries
//   preditorUpdate, lastIndex, missPredict, lastBranch       : predictor update
//   btbUpdate, typeBranch, target, branchAddr                : BTB write
//   count                            : occupied entries
//   overflow                         : sticky, a qualified retire was dropped
module bpu_update_sched
    import bpu_update_sched_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PREDITOR_DEPTH = 64,
    parameter int unsigned QUEUE_DEPTH    = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [1:0]                          retValid,
    input  logic [1:0]                          retCond,
    input  logic [1:0]                          retTaken,
    input  logic [1:0]                          retMiss,
    input  logic [1:0]                          retBtbWr,
    input  logic [1:0]                          retType,
    input  logic [2*$clog2(PREDITOR_DEPTH)-1:0] retIndex,
    input  logic [2*XLEN-1:0]                   retTarget,
    input  logic [2*XLEN-1:0]                   retAddr,
    output logic                                retReady,
    output logic                                preditorUpdate,
    output logic [$clog2(PREDITOR_DEPTH)-1:0]   lastIndex,
    output logic                                missPredict,
    output logic                                lastBranch,
    output logic                                btbUpdate,
    output logic                                typeBranch,
    output logic [XLEN-1:0]                     target,
    output logic [XLEN-1:0]                     branchAddr,
    output logic [$clog2(QUEUE_DEPTH):0]        count,
    output logic                                overflow
);

    localparam int unsigned IW = $clog2(PREDITOR_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned EW = entry_width(IW, XLEN);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    entry_flags_t  lane_flags_s [LANES];
    logic [EW-1:0] lane_entry_s [LANES];
    logic [LANES-1:0] qual_s;
    logic [1:0]    n_qual_s;
    logic [1:0]    accept_s;
    logic          drop_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] free_s;
    logic          wr0_en_s;
    logic          wr1_en_s;
    logic [EW-1:0] wr0_data_s;
    logic [EW-1:0] head_s;
    entry_flags_t  head_flags_s;
    logic          overflow_r;

    // Pack each retire lane into a queue entry and decide whether it needs queuing.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_flags_s[l].cond    = retCond[l];
            lane_flags_s[l].taken   = retTaken[l];
            lane_flags_s[l].miss    = retMiss[l];
            lane_flags_s[l].btb_wr  = retBtbWr[l];
            lane_flags_s[l].br_type = retType[l];
            lane_entry_s[l] = {lane_flags_s[l], retIndex[l*IW +: IW],
                               retTarget[l*XLEN +: XLEN], retAddr[l*XLEN +: XLEN]};
            qual_s[l] = retValid[l] & (retCond[l] | retBtbWr[l]);
        end
    end

    // Admission: take as many qualified lanes as fit, oldest first. Free space
    // comes from the current count only, so a same-cycle pop gives no credit.
    always_comb begin
        free_s   = DEPTH_C - count_s;
        n_qual_s = {1'b0, qual_s[0]} + {1'b0, qual_s[1]};
        if (free_s >= CW'(2)) begin
            accept_s = n_qual_s;
        end else if (free_s == CW'(1)) begin
            accept_s = (n_qual_s != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            accept_s = 2'd0;
        end
        drop_s     = (accept_s != n_qual_s);
        wr0_en_s   = (accept_s != 2'd0);
        wr1_en_s   = (accept_s == 2'd2);
        // Slot 0 gets lane0 if it qualified, otherwise lane1 moves down to the tail.
        wr0_data_s = qual_s[0] ? lane_entry_s[0] : lane_entry_s[1];
    end

    bpu_update_fifo #(
        .W     (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr0_en    (wr0_en_s),
        .wr0_data  (wr0_data_s),
        .wr1_en    (wr1_en_s),
        .wr1_data  (lane_entry_s[1]),
        .pop       (count_s != CW'(0)),
        .head_data (head_s),
        .count     (count_s)
    );

    // Sticky overflow: set when any qualified lane is dropped, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Head entry drives the BPU directly; fields are meaningful only under the strobes.
    always_comb begin
        head_flags_s   = entry_flags_t'(head_s[EW-1 -: ENTRY_FLAGS]);
        preditorUpdate = (count_s != CW'(0)) & head_flags_s.cond;
        btbUpdate      = (count_s != CW'(0)) & head_flags_s.btb_wr;
        missPredict    = head_flags_s.miss;
        lastBranch     = head_flags_s.taken;
        typeBranch     = head_flags_s.br_type;
        lastIndex      = head_s[2*XLEN +: IW];
        target         = head_s[XLEN +: XLEN];
        branchAddr     = head_s[0 +: XLEN];
        retReady       = (free_s >= CW'(2));
    end

    assign count    = count_s;
    assign overflow = overflow_r;

endmodule
